// File: rtl/divider_seq_66.sv
// Sequential radix-2 restoring divider: 2*div_size-bit dividend by a
// div_size-bit divisor, one quotient bit per clock, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | shifting/subtracting one quotient bit per edge
// DONE  | result held on the outputs until the consumer takes it
module divider_seq_66 #(
  parameter int div_size = 66,
  parameter int iter_w   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*div_size-1:0]   dividend,
  input  logic [div_size-1:0]     divisor,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*div_size-1:0]   quotient,
  output logic [div_size-1:0]     remainder,
  output logic                    div_zero
);

  localparam int q_w = 2 * div_size;
  localparam logic [iter_w-1:0] last_iter = iter_w'(q_w - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [div_size:0]    r;
  logic [q_w-1:0]       q_sh;
  logic [div_size-1:0]  dvsr;
  logic [iter_w-1:0]    cnt;

  logic [div_size+1:0]  diff;
  logic                 ge;
  logic [div_size:0]    r_next;
  logic [q_w-1:0]       q_next;

  // Operand acceptance depends only on the state.
  assign in_ready = (state == IDLE);

  // One restoring step. The stored remainder is always below the divisor, so its
  // top bit is zero and the borrow out of the wide subtraction is the compare.
  always_comb begin
    diff   = {r, q_sh[q_w-1]} - {2'b00, dvsr};
    ge     = ~diff[div_size+1];
    r_next = ge ? diff[div_size:0] : {r[div_size-1:0], q_sh[q_w-1]};
    q_next = {q_sh[q_w-2:0], ge};
  end

  // Control FSM and datapath registers; outputs update only when a result retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      q_sh      <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvsr  <= divisor;
            q_sh  <= dividend;
            r     <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (dvsr == '0) begin
            // Zero divisor retires after a single cycle with a flagged result.
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            r    <= r_next;
            q_sh <= q_next;
            cnt  <= cnt + iter_w'(1);
            if (cnt == last_iter) begin
              quotient  <= q_next;
              remainder <= r_next[div_size-1:0];
              div_zero  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq_66.sv
// Scoreboard bench for divider_seq_66: directed vectors push hand-computed
// results, a negedge monitor pops and compares on every output handshake.
module tb_divider_seq_66;

  localparam int DS = 66;
  localparam int QW = 132;

  typedef struct packed {
    logic [QW-1:0] q;
    logic [DS-1:0] r;
    logic          dz;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] dividend;
  logic [DS-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quotient;
  logic [DS-1:0] remainder;
  logic          div_zero;

  logic          dir_ready;
  logic          rnd_ready;
  bit            rand_mode = 1'b0;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  assign out_ready = rand_mode ? rnd_ready : dir_ready;

  divider_seq_66 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [QW-1:0] act, input logic [QW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got q=%0h r=%0h required no result", quotient, remainder);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", QW'(remainder), QW'(mon_e.r));
        check("div_zero", QW'(div_zero), QW'(mon_e.dz));
      end
    end
  end

  // Random backpressure source for the regression phase.
  initial begin
    rnd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rnd_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push_exp(input logic [QW-1:0] q, input logic [DS-1:0] r, input logic dz);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [QW-1:0] a, input logic [DS-1:0] b);
    int n;
    n = 0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) check("accept_timeout", QW'(in_ready), QW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) check("valid_timeout", QW'(out_valid), QW'(1));
  endtask

  initial begin
    int            n;
    bit            seen;
    logic [QW-1:0] a;
    logic [DS-1:0] b;

    rst = 1'b1; in_valid = 1'b0; dir_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", QW'(out_valid), QW'(0));
    check("rst_in_ready", QW'(in_ready), QW'(1));
    check("rst_quotient", quotient, '0);
    check("rst_remainder", QW'(remainder), '0);
    check("rst_div_zero", QW'(div_zero), '0);
    rst = 1'b0;

    // 100 / 7 with latency check
    dir_ready = 1'b1;
    push_exp(QW'(14), DS'(2), 1'b0);
    issue(QW'(100), DS'(7));
    wait_valid(n);
    check("latency_132", QW'(n), QW'(132));
    check("busy_in_ready", QW'(in_ready), QW'(0));
    @(posedge clk); #1;
    check("in_ready_after_hs", QW'(in_ready), QW'(1));
    check("out_valid_after_hs", QW'(out_valid), QW'(0));

    // full-width operands
    push_exp((QW'(1) << 66) + QW'(1), '0, 1'b0);
    issue('1, '1);
    wait_valid(n);
    @(posedge clk); #1;
    push_exp('1, '0, 1'b0);
    issue('1, DS'(1));
    wait_valid(n);
    @(posedge clk); #1;

    // divide by zero, then a normal op
    push_exp('1, '0, 1'b1);
    issue(QW'(12345), '0);
    wait_valid(n);
    check("latency_div0", QW'(n), QW'(1));
    @(posedge clk); #1;
    push_exp(QW'(3), '0, 1'b0);
    issue(QW'(9), DS'(3));
    wait_valid(n);
    @(posedge clk); #1;

    // backpressure with ignored in_valid pulses
    dir_ready = 1'b0;
    push_exp(QW'(30), DS'(10), 1'b0);
    issue(QW'(1000), DS'(33));
    wait_valid(n);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      dividend = QW'(77 + i);
      divisor  = DS'(5);
      @(posedge clk); #1;
      check("bp_quotient", quotient, QW'(30));
      check("bp_remainder", QW'(remainder), QW'(10));
      check("bp_in_ready", QW'(in_ready), QW'(0));
      check("bp_out_valid", QW'(out_valid), QW'(1));
    end
    in_valid = 1'b0;
    dir_ready = 1'b1;
    @(posedge clk); #1;
    dir_ready = 1'b0;
    check("bp_release_valid", QW'(out_valid), QW'(0));

    // reset in the middle of CALC discards the operation
    dir_ready = 1'b1;
    issue(QW'(20), DS'(3));
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", QW'(in_ready), QW'(1));
    check("midrst_out_valid", QW'(out_valid), QW'(0));
    check("midrst_quotient", quotient, '0);
    check("midrst_remainder", QW'(remainder), '0);
    seen = 1'b0;
    repeat (150) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_stale", QW'(seen), QW'(0));
    push_exp(QW'(10), '0, 1'b0);
    issue(QW'(50), DS'(5));
    wait_valid(n);
    @(posedge clk); #1;

    // random regression with gaps and backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      a = {4'($urandom), $urandom(), $urandom(), $urandom(), $urandom()};
      b = {2'($urandom), $urandom(), $urandom()} >> $urandom_range(0, 65);
      if (i % 13 == 5) b = '0;
      if (b == '0) push_exp('1, '0, 1'b1);
      else push_exp(a / QW'(b), DS'(a % QW'(b)), 1'b0);
      issue(a, b);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    rand_mode = 1'b0;
    check("all_results_drained", QW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
